// File: rtl/ir_rx_pkg.sv
// rtl/ir_rx_pkg.sv - shared types and tick windows for the IR frame capture block
package ir_rx_pkg;

    localparam int WIDTH_W    = 12;
    localparam int DATA_BITS  = 11;
    localparam int FRAME_BITS = 12;

    localparam logic [WIDTH_W-1:0] WIDTH_SAT     = 12'd4095;
    localparam logic [WIDTH_W-1:0] HDR_MARK_MIN  = 12'd800;
    localparam logic [WIDTH_W-1:0] HDR_MARK_MAX  = 12'd1000;
    localparam logic [WIDTH_W-1:0] HDR_SPACE_MIN = 12'd350;
    localparam logic [WIDTH_W-1:0] HDR_SPACE_MAX = 12'd550;
    localparam logic [WIDTH_W-1:0] BIT_MARK_MIN  = 12'd40;
    localparam logic [WIDTH_W-1:0] BIT_MARK_MAX  = 12'd75;
    localparam logic [WIDTH_W-1:0] SPACE0_MIN    = 12'd40;
    localparam logic [WIDTH_W-1:0] SPACE0_MAX    = 12'd75;
    localparam logic [WIDTH_W-1:0] SPACE1_MIN    = 12'd140;
    localparam logic [WIDTH_W-1:0] SPACE1_MAX    = 12'd200;
    localparam logic [WIDTH_W-1:0] TIMEOUT_TICKS = 12'd1200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_MARK,
        ST_HDR_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_DONE,
        ST_ERROR
    } rx_state_t;

    function automatic logic in_window(
        input logic [WIDTH_W-1:0] w,
        input logic [WIDTH_W-1:0] lo,
        input logic [WIDTH_W-1:0] hi
    );
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_frame_capture_if.sv
// rtl/ir_frame_capture_if.sv - IR input and decoded-word handoff to the UART reporting stage
interface ir_frame_capture_if;
    logic        ir_in;
    logic [10:0] ir_recieved_data;
    logic        capture_ready;
    logic        receive_status;
    logic        capture_rst;

    modport master (
        input  ir_in,
        output ir_recieved_data,
        output capture_ready,
        output receive_status,
        output capture_rst
    );

    modport slave (
        output ir_in,
        input  ir_recieved_data,
        input  capture_ready,
        input  receive_status,
        input  capture_rst
    );
endinterface

// File: rtl/ir_edge_filter.sv
// rtl/ir_edge_filter.sv - synchronizer, glitch filter and registered fall/rise pulses
module ir_edge_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ir,
    output logic o_fall,
    output logic o_rise
);
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fall;
    logic             r_rise;

    // Idle line is high, so everything resets to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_ir;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_fall  <= ~r_sync2;
                    r_rise  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_fall = r_fall;
    assign o_rise = r_rise;
endmodule

// File: rtl/ir_frame_capture.sv
// rtl/ir_frame_capture.sv - pulse-distance IR frame decoder with parity check and status flags
module ir_frame_capture
    import ir_rx_pkg::*;
#(
    parameter int TICK_DIV = 500,
    parameter int FILT_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ir_frame_capture_if.master bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic                  w_fall;
    logic                  w_rise;
    logic                  w_edge;
    logic                  w_tick;
    logic                  w_timeout;
    logic                  w_is_zero;
    logic                  w_is_one;

    logic [DIV_W-1:0]      r_div;
    logic [WIDTH_W-1:0]    r_width;
    rx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bitcnt;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_status;
    logic                  r_ready;
    logic                  r_capture_rst;

    ir_edge_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_edge_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ir   (bus.ir_in),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    assign w_edge    = w_fall | w_rise;
    assign w_tick    = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_timeout = (r_width > TIMEOUT_TICKS);
    assign w_is_zero = in_window(r_width, SPACE0_MIN, SPACE0_MAX);
    assign w_is_one  = in_window(r_width, SPACE1_MIN, SPACE1_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Cleared on the edge itself, so the value seen on an edge cycle is the width just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= '0;
        end else if (w_edge) begin
            r_width <= '0;
        end else if (w_tick && (r_width != WIDTH_SAT)) begin
            r_width <= r_width + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_data        <= '0;
            r_status      <= 1'b0;
            r_ready       <= 1'b0;
            r_capture_rst <= 1'b1;
        end else begin
            r_capture_rst <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_HDR_MARK;
                    end
                end
                // A bad header is treated as noise: no flags move.
                ST_HDR_MARK: begin
                    if (w_rise) begin
                        if (in_window(r_width, HDR_MARK_MIN, HDR_MARK_MAX)) begin
                            r_capture_rst <= 1'b0;
                            r_ready       <= 1'b0;
                            r_shift       <= '0;
                            r_bitcnt      <= '0;
                            r_state       <= ST_HDR_SPACE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HDR_SPACE: begin
                    if (w_fall) begin
                        r_state <= in_window(r_width, HDR_SPACE_MIN, HDR_SPACE_MAX)
                                   ? ST_BIT_MARK : ST_ERROR;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_BIT_MARK: begin
                    if (w_rise) begin
                        r_state <= in_window(r_width, BIT_MARK_MIN, BIT_MARK_MAX)
                                   ? ST_BIT_SPACE : ST_ERROR;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_BIT_SPACE: begin
                    if (w_fall) begin
                        if (w_is_zero || w_is_one) begin
                            r_shift  <= {w_is_one, r_shift[FRAME_BITS-1:1]};
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_state  <= (r_bitcnt == 4'(FRAME_BITS - 1))
                                        ? ST_STOP_MARK : ST_BIT_MARK;
                        end else begin
                            r_state <= ST_ERROR;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_STOP_MARK: begin
                    if (w_rise) begin
                        if (in_window(r_width, BIT_MARK_MIN, BIT_MARK_MAX) && !(^r_shift)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ERROR;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_DONE: begin
                    r_data   <= r_shift[DATA_BITS-1:0];
                    r_status <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                ST_ERROR: begin
                    r_status <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ir_recieved_data = r_data;
    assign bus.capture_ready    = r_ready;
    assign bus.receive_status   = r_status;
    assign bus.capture_rst      = r_capture_rst;
endmodule

// File: tb/tb_ir_frame_capture.sv
// tb/tb_ir_frame_capture.sv - scoreboard bench for the IR frame capture block
module tb_ir_frame_capture;
    localparam int TICK_DIV = 2;
    localparam int FILT_LEN = 4;

    typedef struct {
        logic [10:0] data;
        logic        status;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ir_frame_capture_if bus ();

    ir_frame_capture #(
        .TICK_DIV (TICK_DIV),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          crst_exp = 0;
    int          crst_seen = 0;
    exp_t        exp_q[$];
    logic [10:0] last_good = 11'h0;
    logic        prev_ready = 1'b0;
    logic        prev_crst_lo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: frame results are popped when capture_ready rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready   = 1'b0;
            prev_crst_lo = 1'b0;
        end else begin
            if (prev_crst_lo) check("capture_rst_width", bus.capture_rst, 1);
            if (bus.capture_rst == 1'b0) begin
                crst_seen++;
                check("ready_low_with_crst", bus.capture_ready, 0);
            end
            prev_crst_lo = (bus.capture_rst == 1'b0);
            if (bus.capture_ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", bus.ir_recieved_data, e.data);
                    check("sb_status", bus.receive_status, e.status);
                end
            end
            prev_ready = bus.capture_ready;
        end
    end

    task automatic drive(input logic lvl, input int ticks);
        bus.ir_in = lvl;
        repeat (ticks * TICK_DIV) @(negedge clk);
    endtask

    task automatic space_glitch(input int ticks);
        int half;
        half = ticks * TICK_DIV / 2;
        bus.ir_in = 1'b1;
        repeat (half) @(negedge clk);
        bus.ir_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.ir_in = 1'b1;
        repeat (ticks * TICK_DIV - half - 3) @(negedge clk);
    endtask

    // Reference: a frame with a good header yields a result; only a clean frame
    // with even overall parity updates the word.
    task automatic send_frame(input logic [10:0] d, input bit flip_par, input int hm,
                              input int bad_idx, input bit glitch, input bit rand_w);
        logic [11:0] bits;
        exp_t        e;
        int          mk, sp;
        bits = {(^d) ^ flip_par, d};
        if (hm >= 800 && hm <= 1000) begin
            crst_exp++;
            if (bad_idx < 0 && !flip_par) begin
                e.data = d; e.status = 1'b1; last_good = d;
            end else begin
                e.data = last_good; e.status = 1'b0;
            end
            exp_q.push_back(e);
        end
        drive(1'b0, hm);
        drive(1'b1, rand_w ? int'($urandom_range(370, 530)) : 450);
        for (int i = 0; i < 12; i++) begin
            mk = rand_w ? int'($urandom_range(45, 70)) : 56;
            drive(1'b0, mk);
            if (bits[i]) sp = rand_w ? int'($urandom_range(145, 190)) : 170;
            else         sp = rand_w ? int'($urandom_range(45, 70)) : 56;
            if (i == bad_idx) sp = 100;
            if (glitch) space_glitch(sp);
            else        drive(1'b1, sp);
        end
        drive(1'b0, 56);
        drive(1'b1, 30);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_crst_count"}, crst_seen, crst_exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, bus.ir_recieved_data, 0);
        check({tag, "_ready"}, bus.capture_ready, 0);
        check({tag, "_status"}, bus.receive_status, 0);
        check({tag, "_crst"}, bus.capture_rst, 1);
    endtask

    initial begin
        int crst_lo_cycles;
        exp_t e;
        bus.ir_in = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (10000) @(negedge clk);
        check_reset_vals("idle");
        check("idle_crst_count", crst_seen, 0);

        send_frame(11'h5A3, 1'b0, 900, -1, 1'b0, 1'b0);
        wait_idle("valid");
        check("valid_data", bus.ir_recieved_data, 11'h5A3);
        check("valid_status", bus.receive_status, 1);

        send_frame(11'h5A3, 1'b1, 900, -1, 1'b0, 1'b0);
        wait_idle("parity");
        check("parity_ready", bus.capture_ready, 1);
        check("parity_status", bus.receive_status, 0);
        check("parity_data", bus.ir_recieved_data, 11'h5A3);

        send_frame(11'h3C5, 1'b0, 700, -1, 1'b0, 1'b0);
        wait_idle("short_hdr");
        check("short_hdr_ready", bus.capture_ready, 1);
        check("short_hdr_status", bus.receive_status, 0);

        send_frame(11'h0F0, 1'b0, 900, 4, 1'b0, 1'b0);
        wait_idle("bad_space");
        check("bad_space_status", bus.receive_status, 0);
        check("bad_space_data", bus.ir_recieved_data, 11'h5A3);

        send_frame(11'h001, 1'b0, 900, -1, 1'b1, 1'b0);
        wait_idle("glitch");
        check("glitch_data", bus.ir_recieved_data, 11'h001);
        check("glitch_status", bus.receive_status, 1);

        crst_exp++;
        e.data = last_good; e.status = 1'b0;
        exp_q.push_back(e);
        drive(1'b0, 900);
        drive(1'b1, 450);
        drive(1'b0, 1300);
        drive(1'b1, 30);
        wait_idle("timeout");
        check("timeout_status", bus.receive_status, 0);
        check("timeout_data", bus.ir_recieved_data, 11'h001);

        for (int k = 0; k < 3; k++) begin
            send_frame(11'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(820, 980)),
                       -1, 1'b0, 1'b1);
            wait_idle("random");
        end

        crst_exp++;
        drive(1'b0, 900);
        drive(1'b1, 200);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        crst_lo_cycles = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.capture_rst == 1'b0) crst_lo_cycles++;
        end
        rst_n = 1'b1;
        last_good = 11'h0;
        repeat (50) begin
            @(negedge clk);
            if (bus.capture_rst == 1'b0) crst_lo_cycles++;
        end
        check("async_rst_crst_low", crst_lo_cycles, 0);
        check_reset_vals("post_rst");

        send_frame(11'($urandom), 1'b0, 900, -1, 1'b0, 1'b1);
        wait_idle("recover");
        check("recover_status", bus.receive_status, 1);
        check("recover_data", bus.ir_recieved_data, last_good);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
